alu_issue_ctrl: RTL and testbench

Initiator and consumer side of the logic-unit interface.
- Accepts packed instructions on a valid/ready channel and reads operands from an internal register file.
- Drives opcode and operands to the combinational logic unit, then captures its result and compare flags.
- Writes results back and returns a completion record on a second valid/ready channel.
- Sits between the instruction fetch/decode front end and the ALU datapath.

---
 rtl/alu_issue_ctrl_pkg.sv | 31 +++
 rtl/alu_issue_ctrl_regfile.sv | 56 +++++
 rtl/alu_issue_ctrl.sv | 149 ++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_ctrl_pkg.sv
// Shared types for the ALU issue path: datapath width, logic-unit opcodes,
// issue FSM states and the logic-op classifier.
package CPU_package;

    localparam int DATA_WIDTH = 8;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_NOTA = 3'd3,
        OP_NOTB = 3'd4,
        OP_CPR  = 3'd5
    } enum_alu_opcode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } enum_issue_state_t;

    // Encodings 6 and 7 are not served by the logic unit.
    function automatic logic is_logic_op(input enum_alu_opcode_t op);
        case (op)
            OP_AND, OP_OR, OP_XOR, OP_NOTA, OP_NOTB, OP_CPR: return 1'b1;
            default:                                         return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_regfile.sv
// Architectural register file: two combinational read ports, one write port
// shared by external loads and ALU writeback; register 0 is constant zero.
module alu_regfile
    import CPU_package::*;
#(
    parameter int NUM_REGS = 8,
    parameter int REG_AW   = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_AW-1:0]     rd_addr_a,
    output logic [DATA_WIDTH-1:0] rd_data_a,
    input  logic [REG_AW-1:0]     rd_addr_b,
    output logic [DATA_WIDTH-1:0] rd_data_b,
    input  logic                  ld_en,
    input  logic [REG_AW-1:0]     ld_addr,
    input  logic [DATA_WIDTH-1:0] ld_data,
    input  logic                  wb_en,
    input  logic [REG_AW-1:0]     wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data
);

    logic                  wr_en;
    logic [REG_AW-1:0]     wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    // Loads are refused while a writeback is pending, so the two never collide;
    // writeback is given priority anyway.
    always_comb begin
        wr_en   = wb_en || ld_en;
        wr_addr = wb_en ? wb_addr : ld_addr;
        wr_data = wb_en ? wb_data : ld_data;
    end

    assign regs[0] = '0;

    genvar gi;
    generate
        for (gi = 1; gi < NUM_REGS; gi++) begin : g_reg
            logic [DATA_WIDTH-1:0] q_reg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    q_reg <= '0;
                end else if (wr_en && wr_addr == REG_AW'(gi)) begin
                    q_reg <= wr_data;
                end
            end
            assign regs[gi] = q_reg;
        end
    endgenerate

    assign rd_data_a = regs[rd_addr_a];
    assign rd_data_b = regs[rd_addr_b];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the logic unit: accepts one instruction at a time,
// reads operands, drives the unit, writes back and returns a completion record.
module alu_issue_ctrl
    import CPU_package::*;
#(
    parameter int NUM_REGS = 8,
    parameter int REG_AW   = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  enum_alu_opcode_t      instr_opcode,
    input  logic [REG_AW-1:0]     instr_rd,
    input  logic [REG_AW-1:0]     instr_rs1,
    input  logic [REG_AW-1:0]     instr_rs2,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [REG_AW-1:0]     ld_addr,
    input  logic [DATA_WIDTH-1:0] ld_data,
    output enum_alu_opcode_t      alu_opcode,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic [2:0]            alu_flag,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [DATA_WIDTH-1:0] res_data,
    output logic [REG_AW-1:0]     res_rd,
    output logic                  res_err,
    output logic [2:0]            flags_q
);

    enum_issue_state_t     state_reg;
    enum_alu_opcode_t      op_reg;
    logic [REG_AW-1:0]     rd_reg;
    logic [REG_AW-1:0]     rs1_reg;
    logic [REG_AW-1:0]     rs2_reg;
    enum_alu_opcode_t      alu_opcode_reg;
    logic [DATA_WIDTH-1:0] alu_a_reg;
    logic [DATA_WIDTH-1:0] alu_b_reg;
    logic                  res_valid_reg;
    logic [DATA_WIDTH-1:0] res_data_reg;
    logic [REG_AW-1:0]     res_rd_reg;
    logic                  res_err_reg;
    logic [2:0]            flags_reg;

    logic [DATA_WIDTH-1:0] rf_a;
    logic [DATA_WIDTH-1:0] rf_b;
    logic                  ld_fire;
    logic                  wb_en;
    logic                  is_data_op;

    // Handshake readies follow the state directly but are held low during reset.
    assign instr_ready = !rst && (state_reg == IDLE);
    assign ld_ready    = !rst && (state_reg != EXEC);
    assign ld_fire     = ld_valid && ld_ready;
    assign is_data_op  = is_logic_op(op_reg) && (op_reg != OP_CPR);
    assign wb_en       = (state_reg == EXEC) && is_data_op;

    alu_regfile #(
        .NUM_REGS (NUM_REGS),
        .REG_AW   (REG_AW)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .rd_addr_a (rs1_reg),
        .rd_data_a (rf_a),
        .rd_addr_b (rs2_reg),
        .rd_data_b (rf_b),
        .ld_en     (ld_fire),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .wb_en     (wb_en),
        .wb_addr   (rd_reg),
        .wb_data   (alu_result)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            op_reg         <= OP_AND;
            rd_reg         <= '0;
            rs1_reg        <= '0;
            rs2_reg        <= '0;
            alu_opcode_reg <= OP_AND;
            alu_a_reg      <= '0;
            alu_b_reg      <= '0;
            res_valid_reg  <= 1'b0;
            res_data_reg   <= '0;
            res_rd_reg     <= '0;
            res_err_reg    <= 1'b0;
            flags_reg      <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (instr_valid) begin
                        op_reg    <= instr_opcode;
                        rd_reg    <= instr_rd;
                        rs1_reg   <= instr_rs1;
                        rs2_reg   <= instr_rs2;
                        state_reg <= READ;
                    end
                end
                READ: begin
                    alu_opcode_reg <= op_reg;
                    alu_a_reg      <= rf_a;
                    alu_b_reg      <= rf_b;
                    state_reg      <= EXEC;
                end
                EXEC: begin
                    res_rd_reg <= rd_reg;
                    if (is_data_op) begin
                        res_data_reg <= alu_result;
                        res_err_reg  <= 1'b0;
                    end else if (op_reg == OP_CPR) begin
                        flags_reg    <= alu_flag;
                        res_data_reg <= '0;
                        res_err_reg  <= 1'b0;
                    end else begin
                        res_data_reg <= '0;
                        res_err_reg  <= 1'b1;
                    end
                    state_reg <= WB;
                end
                WB: begin
                    // First WB cycle raises res_valid; the record then waits for res_ready.
                    if (!res_valid_reg) begin
                        res_valid_reg <= 1'b1;
                    end else if (res_ready) begin
                        res_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign alu_opcode = alu_opcode_reg;
    assign alu_a      = alu_a_reg;
    assign alu_b      = alu_b_reg;
    assign res_valid  = res_valid_reg;
    assign res_data   = res_data_reg;
    assign res_rd     = res_rd_reg;
    assign res_err    = res_err_reg;
    assign flags_q    = flags_reg;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural logic unit, register-file model and a
// queue of expected completion records compared when each record appears.
module tb_alu_issue_ctrl;
    import CPU_package::*;

    localparam int DW = DATA_WIDTH;
    localparam int AW = 3;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [AW-1:0] rd;
        logic          err;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             instr_valid = 1'b0;
    logic             instr_ready;
    enum_alu_opcode_t instr_opcode = OP_AND;
    logic [AW-1:0]    instr_rd = '0;
    logic [AW-1:0]    instr_rs1 = '0;
    logic [AW-1:0]    instr_rs2 = '0;
    logic             ld_valid = 1'b0;
    logic             ld_ready;
    logic [AW-1:0]    ld_addr = '0;
    logic [DW-1:0]    ld_data = '0;
    enum_alu_opcode_t alu_opcode;
    logic [DW-1:0]    alu_a;
    logic [DW-1:0]    alu_b;
    logic [DW-1:0]    alu_result;
    logic [2:0]       alu_flag;
    logic             res_valid;
    logic             res_ready = 1'b1;
    logic [DW-1:0]    res_data;
    logic [AW-1:0]    res_rd;
    logic             res_err;
    logic [2:0]       flags_q;

    int            n_checks = 0;
    int            n_pass   = 0;
    logic [DW-1:0] m_rf [8];
    logic [2:0]    m_flags;
    exp_t          sb_q [$];

    always #5 clk = ~clk;

    alu_issue_ctrl #(.NUM_REGS(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr_opcode (instr_opcode),
        .instr_rd     (instr_rd),
        .instr_rs1    (instr_rs1),
        .instr_rs2    (instr_rs2),
        .ld_valid     (ld_valid),
        .ld_ready     (ld_ready),
        .ld_addr      (ld_addr),
        .ld_data      (ld_data),
        .alu_opcode   (alu_opcode),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_result   (alu_result),
        .alu_flag     (alu_flag),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .res_rd       (res_rd),
        .res_err      (res_err),
        .flags_q      (flags_q)
    );

    // Combinational logic unit; unsupported opcodes produce a nonzero sum on purpose.
    always_comb begin
        case (alu_opcode)
            OP_AND:  alu_result = alu_a & alu_b;
            OP_OR:   alu_result = alu_a | alu_b;
            OP_XOR:  alu_result = alu_a ^ alu_b;
            OP_NOTA: alu_result = ~alu_a;
            OP_NOTB: alu_result = ~alu_b;
            default: alu_result = alu_a + alu_b + 8'd1;
        endcase
        alu_flag = {alu_a == alu_b, alu_a > alu_b, alu_a < alu_b};
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic do_load(input int addr, input logic [DW-1:0] val);
        @(negedge clk);
        ld_valid = 1'b1;
        ld_addr  = AW'(addr);
        ld_data  = val;
        check_eq("ld_ready_idle", ld_ready, 1);
        if (addr != 0) m_rf[addr] = val;
        @(negedge clk);
        ld_valid = 1'b0;
        $display("load r%0d <= %0h", addr, val);
    endtask

    // ld_mode: 0 none, 1 load rs1 during READ, 2 attempt load of rs1 during EXEC.
    task automatic issue(input logic [2:0] op, input int rd, input int rs1, input int rs2,
                         input int hold, input int ld_mode, input logic [DW-1:0] ld_val);
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] r;
        exp_t          e;
        int            n;
        @(negedge clk);
        instr_valid  = 1'b1;
        instr_opcode = enum_alu_opcode_t'(op);
        instr_rd     = AW'(rd);
        instr_rs1    = AW'(rs1);
        instr_rs2    = AW'(rs2);
        res_ready    = (hold == 0);
        n = 0;
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("instr_accept", instr_ready, 1);
        a = (rs1 == 0) ? '0 : m_rf[rs1];
        b = (rs2 == 0) ? '0 : m_rf[rs2];
        case (op)
            3'd0:    r = a & b;
            3'd1:    r = a | b;
            3'd2:    r = a ^ b;
            3'd3:    r = ~a;
            3'd4:    r = ~b;
            default: r = '0;
        endcase
        e.data = (op < 3'd5) ? r : '0;
        e.rd   = AW'(rd);
        e.err  = (op > 3'd5);
        if (op == 3'd5) m_flags = {a == b, a > b, a < b};
        sb_q.push_back(e);

        @(negedge clk);
        instr_valid = 1'b0;
        check_eq("busy_instr_ready", instr_ready, 0);
        if (ld_mode == 1) begin
            ld_valid = 1'b1;
            ld_addr  = AW'(rs1);
            ld_data  = ld_val;
            check_eq("ld_ready_read", ld_ready, 1);
        end
        @(negedge clk);
        ld_valid = 1'b0;
        check_eq("lat_edge1", res_valid, 0);
        if (ld_mode == 1 && rs1 != 0) m_rf[rs1] = ld_val;
        if (ld_mode == 2) begin
            ld_valid = 1'b1;
            ld_addr  = AW'(rs1);
            ld_data  = ld_val;
            check_eq("ld_ready_exec", ld_ready, 0);
        end
        @(negedge clk);
        ld_valid = 1'b0;
        check_eq("lat_edge2", res_valid, 0);
        if (op < 3'd5 && rd != 0) m_rf[rd] = r;
        @(negedge clk);
        check_eq("lat_edge3", res_valid, 1);
        e = sb_q.pop_front();
        check_eq("res_data", res_data, e.data);
        check_eq("res_rd", res_rd, e.rd);
        check_eq("res_err", res_err, e.err);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check_eq("hold_valid", res_valid, 1);
            check_eq("hold_data", res_data, e.data);
            check_eq("hold_rd", res_rd, e.rd);
            check_eq("hold_err", res_err, e.err);
            check_eq("hold_instr_ready", instr_ready, 0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        check_eq("post_hs_valid", res_valid, 0);
        check_eq("post_hs_instr_ready", instr_ready, 1);
        check_eq("flags_q", flags_q, m_flags);
        $display("op=%0d rd=%0d rs1=%0d rs2=%0d -> data=%0h err=%0b flags=%03b",
                 op, rd, rs1, rs2, e.data, e.err, m_flags);
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_res_valid"}, res_valid, 0);
        check_eq({tag, "_instr_ready"}, instr_ready, 0);
        check_eq({tag, "_ld_ready"}, ld_ready, 0);
        check_eq({tag, "_flags"}, flags_q, 0);
        check_eq({tag, "_alu_op"}, 32'(alu_opcode), 0);
        check_eq({tag, "_alu_a"}, alu_a, 0);
        check_eq({tag, "_alu_b"}, alu_b, 0);
        check_eq({tag, "_res_data"}, res_data, 0);
        check_eq({tag, "_res_err"}, res_err, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 8; i++) m_rf[i] = '0;
        m_flags = '0;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;
        @(negedge clk);
        check_eq("idle_instr_ready", instr_ready, 1);

        // AND and readback of r3
        do_load(1, 8'hA5);
        do_load(2, 8'h0F);
        issue(3'd0, 3, 1, 2, 0, 0, 8'h00);
        issue(3'd1, 0, 3, 0, 0, 0, 8'h00);

        // Compare flags, then confirm a data op leaves them alone
        do_load(1, 8'h0F);
        issue(3'd5, 4, 1, 2, 0, 0, 8'h00);
        do_load(1, 8'h10);
        issue(3'd5, 4, 1, 2, 0, 0, 8'h00);
        issue(3'd0, 4, 1, 2, 0, 0, 8'h00);

        // Register 0 stays zero
        issue(3'd2, 0, 1, 1, 0, 0, 8'h00);
        do_load(0, 8'h55);
        issue(3'd1, 5, 0, 0, 0, 0, 8'h00);
        issue(3'd3, 5, 0, 2, 0, 0, 8'h00);
        issue(3'd4, 6, 1, 2, 0, 0, 8'h00);

        // Back-pressure on the result channel
        issue(3'd1, 7, 1, 2, 5, 0, 8'h00);

        // Illegal opcode with a refused load during EXEC, then confirm r3/r5
        issue(3'd6, 3, 5, 1, 0, 2, 8'h77);
        issue(3'd7, 2, 3, 1, 1, 0, 8'h00);
        issue(3'd1, 0, 3, 3, 0, 0, 8'h00);
        issue(3'd1, 0, 5, 5, 0, 0, 8'h00);

        // Load during READ does not affect operands being read
        issue(3'd0, 2, 1, 1, 0, 1, 8'h3C);
        issue(3'd1, 0, 1, 1, 0, 0, 8'h00);

        // Reset while in EXEC
        @(negedge clk);
        instr_valid  = 1'b1;
        instr_opcode = OP_OR;
        instr_rd     = 3'd3;
        instr_rs1    = 3'd1;
        instr_rs2    = 3'd2;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_state("exec_rst");
        rst = 1'b0;
        for (int i = 0; i < 8; i++) m_rf[i] = '0;
        m_flags = '0;
        sb_q.delete();
        @(negedge clk);
        check_eq("exec_rst_idle", instr_ready, 1);
        $display("reset during EXEC applied");
        for (int i = 1; i < 8; i++) issue(3'd1, 0, i, i, 0, 0, 8'h00);

        // Randomised mix
        for (int i = 1; i < 8; i++) do_load(i, 8'($urandom));
        for (int i = 0; i < 12; i++) begin
            issue(3'($urandom_range(0, 7)), $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 7), $urandom_range(0, 2), $urandom_range(0, 1),
                  8'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
